// File: rtl/branch_resolve_unit_if.sv
// Decode-stage branch resolution bus. The pipeline side (master) drives the
// decode instruction fields and the hazard/condition inputs. The branch
// resolve unit (slave) returns the execute enable, the stall and flush
// controls, and the PC/LR update strobes.
interface branch_resolve_unit_if #(
    parameter int PC_W = 32
);
    logic            id_valid;
    logic            id_is_branch;
    logic            id_link;
    logic [23:0]     id_imm24;
    logic [PC_W-1:0] id_pc;
    logic            ex_s_pending;
    logic            cond_pass;
    logic            exec_en;
    logic            stall;
    logic            flush;
    logic            pc_ld;
    logic [PC_W-1:0] pc_target;
    logic            lr_we;
    logic [PC_W-1:0] lr_data;

    modport master (
        output id_valid, id_is_branch, id_link, id_imm24, id_pc,
               ex_s_pending, cond_pass,
        input  exec_en, stall, flush, pc_ld, pc_target, lr_we, lr_data
    );

    modport slave (
        input  id_valid, id_is_branch, id_link, id_imm24, id_pc,
               ex_s_pending, cond_pass,
        output exec_en, stall, flush, pc_ld, pc_target, lr_we, lr_data
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit. Gates execution of the decode instruction on the
// condition test. Inserts one stall cycle when the instruction in execute is
// about to load the flags. For a taken B/BL it loads the PC, writes LR for BL
// and holds flush for FLUSH_CYCLES cycles so the younger slots are discarded.
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int PC_W         = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    branch_resolve_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLAG_WAIT = 2'd1,
        FLUSH     = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [2:0]      fcnt;
    logic            resolve;
    logic            take;
    logic            stall_c;
    logic            exec_c;
    logic [PC_W-1:0] target_c;
    logic [PC_W-1:0] link_c;
    logic            flush_q;
    logic            pc_ld_q;
    logic            lr_we_q;
    logic [PC_W-1:0] pc_target_q;
    logic [PC_W-1:0] lr_data_q;

    // Branch target is PC+8 plus the sign-extended word offset; both sums
    // wrap modulo 2^PC_W.
    assign target_c = bus.id_pc + PC_W'(8) + PC_W'($signed({bus.id_imm24, 2'b00}));
    assign link_c   = bus.id_pc + PC_W'(4);

    // Next-state decode: hazard detection, resolve point and flush exit.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        state_nxt = state;
        stall_c   = 1'b0;
        exec_c    = 1'b0;
        resolve   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.id_valid) begin
                    if (bus.ex_s_pending) begin
                        // Flags are stale this cycle, so cond_pass is not trusted.
                        stall_c   = 1'b1;
                        state_nxt = FLAG_WAIT;
                    end else begin
                        resolve = 1'b1;
                    end
                end
            end
            FLAG_WAIT: begin
                // EX now holds the bubble, so ex_s_pending is irrelevant here.
                if (bus.id_valid) resolve = 1'b1;
                else              state_nxt = IDLE;
            end
            FLUSH: begin
                if (fcnt <= 3'd1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        take = resolve & bus.id_is_branch & bus.cond_pass;
        if (resolve) begin
            exec_c    = bus.cond_pass;
            state_nxt = take ? FLUSH : IDLE;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign bus.stall     = stall_c & reset_n;
    assign bus.exec_en   = exec_c & reset_n;
    assign bus.flush     = flush_q;
    assign bus.pc_ld     = pc_ld_q;
    assign bus.lr_we     = lr_we_q;
    assign bus.pc_target = pc_target_q;
    assign bus.lr_data   = lr_data_q;

    // State register and flush counter.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state <= IDLE;
            fcnt  <= 3'd0;
        end else begin
            state <= state_nxt;
            if (take)                fcnt <= 3'(FLUSH_CYCLES);
            else if (state == FLUSH) fcnt <= fcnt - 3'd1;
        end
    end

    // Registered strobes plus the target/return-address holding registers.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: pc_target/lr_data are reset too, so a reset mid-branch leaves no stale address.
        if (!reset_n) begin
            flush_q     <= 1'b0;
            pc_ld_q     <= 1'b0;
            lr_we_q     <= 1'b0;
            pc_target_q <= '0;
            lr_data_q   <= '0;
        end else begin
            flush_q <= (state_nxt == FLUSH);
            pc_ld_q <= take;
            lr_we_q <= take & bus.id_link;
            if (take)               pc_target_q <= target_c;
            if (take & bus.id_link) lr_data_q   <= link_c;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit. The stimulus process drives one decode
// cycle at a time and queues the outputs expected during that cycle. The
// monitor process pops one entry per cycle and compares it with the DUT.
module tb_branch_resolve_unit;
    localparam int PC_W = 32;

    typedef struct {
        logic        stall;
        logic        exec_en;
        logic        flush;
        logic        pc_ld;
        logic        lr_we;
        logic [31:0] pc_target;
        logic [31:0] lr_data;
        string       name;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    logic [31:0] exp_tgt;
    logic [31:0] exp_lr;

    branch_resolve_unit_if #(.PC_W(PC_W)) bus ();

    branch_resolve_unit #(.FLUSH_CYCLES(2), .PC_W(PC_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue the
    // outputs expected while those inputs are applied.
    task automatic step(input logic rst, input logic v, input logic br, input logic lk,
                        input logic [23:0] imm, input logic [31:0] pc,
                        input logic sp, input logic cp,
                        input logic e_st, input logic e_ex, input logic e_fl,
                        input logic e_pl, input logic e_lw, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n          = rst;
        bus.id_valid     = v;
        bus.id_is_branch = br;
        bus.id_link      = lk;
        bus.id_imm24     = imm;
        bus.id_pc        = pc;
        bus.ex_s_pending = sp;
        bus.cond_pass    = cp;
        e.stall     = e_st;
        e.exec_en   = e_ex;
        e.flush     = e_fl;
        e.pc_ld     = e_pl;
        e.lr_we     = e_lw;
        e.pc_target = exp_tgt;
        e.lr_data   = exp_lr;
        e.name      = nm;
        sb.push_back(e);
    endtask

    // Monitor: compare every output on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({e.name, " stall"},     32'(bus.stall),   32'(e.stall));
                check({e.name, " exec_en"},   32'(bus.exec_en), 32'(e.exec_en));
                check({e.name, " flush"},     32'(bus.flush),   32'(e.flush));
                check({e.name, " pc_ld"},     32'(bus.pc_ld),   32'(e.pc_ld));
                check({e.name, " lr_we"},     32'(bus.lr_we),   32'(e.lr_we));
                check({e.name, " pc_target"}, bus.pc_target,    e.pc_target);
                check({e.name, " lr_data"},   bus.lr_data,      e.lr_data);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_tgt  = 32'h0;
        exp_lr   = 32'h0;
        reset_n          = 1'b0;
        bus.id_valid     = 1'b0;
        bus.id_is_branch = 1'b0;
        bus.id_link      = 1'b0;
        bus.id_imm24     = 24'h0;
        bus.id_pc        = 32'h0;
        bus.ex_s_pending = 1'b0;
        bus.cond_pass    = 1'b0;

        //   rst v br lk imm          pc            sp cp  st ex fl pl lw
        step(0, 1, 1, 0, 24'h0,      32'h0,        0, 1,  0, 0, 0, 0, 0, "reset");
        step(1, 0, 0, 0, 24'h0,      32'h0,        0, 0,  0, 0, 0, 0, 0, "idle");
        // BEQ back by 2 words: 0x100 + 8 - 8 = 0x100.
        step(1, 1, 1, 0, 24'hFFFFFE, 32'h100,      0, 1,  0, 1, 0, 0, 0, "beq_resolve");
        exp_tgt = 32'h100;
        step(1, 0, 0, 0, 24'h0,      32'h0,        0, 0,  0, 0, 1, 1, 0, "beq_flush1");
        step(1, 0, 0, 0, 24'h0,      32'h0,        0, 0,  0, 0, 1, 0, 0, "beq_flush2");
        step(1, 0, 0, 0, 24'h0,      32'h0,        0, 0,  0, 0, 0, 0, 0, "beq_done");
        // BL: 0x20 + 8 + 12 = 0x34, return address 0x24.
        step(1, 1, 1, 1, 24'd3,      32'h20,       0, 1,  0, 1, 0, 0, 0, "bl_resolve");
        exp_tgt = 32'h34;
        exp_lr  = 32'h24;
        step(1, 0, 0, 0, 24'h0,      32'h0,        0, 0,  0, 0, 1, 1, 1, "bl_flush1");
        step(1, 0, 0, 0, 24'h0,      32'h0,        0, 0,  0, 0, 1, 0, 0, "bl_flush2");
        // Not-taken branch, executed ADD, not-taken BL.
        step(1, 1, 1, 0, 24'd5,      32'h40,       0, 0,  0, 0, 0, 0, 0, "bne_not_taken");
        step(1, 1, 0, 0, 24'h0,      32'h44,       0, 1,  0, 1, 0, 0, 0, "add_exec");
        step(1, 1, 1, 1, 24'd9,      32'h48,       0, 0,  0, 0, 0, 0, 0, "bl_not_taken");
        step(1, 0, 0, 0, 24'h0,      32'h0,        0, 0,  0, 0, 0, 0, 0, "no_strobes");
        // Flag hazard: one stall, then resolve (0x200 + 8 + 4 = 0x20C).
        step(1, 1, 1, 0, 24'd1,      32'h200,      1, 1,  1, 0, 0, 0, 0, "hazard_stall");
        step(1, 1, 1, 0, 24'd1,      32'h200,      1, 1,  0, 1, 0, 0, 0, "hazard_resolve");
        exp_tgt = 32'h20C;
        step(1, 0, 0, 0, 24'h0,      32'h0,        0, 0,  0, 0, 1, 1, 0, "hazard_flush1");
        step(1, 0, 0, 0, 24'h0,      32'h0,        0, 0,  0, 0, 1, 0, 0, "hazard_flush2");
        // Hazard whose decode slot empties during FLAG_WAIT.
        step(1, 1, 0, 0, 24'h0,      32'h210,      1, 0,  1, 0, 0, 0, 0, "add_stall");
        step(1, 0, 0, 0, 24'h0,      32'h0,        0, 0,  0, 0, 0, 0, 0, "flag_wait_empty");
        step(1, 1, 0, 0, 24'h0,      32'h214,      1, 1,  1, 0, 0, 0, 0, "idle_again_stall");
        step(1, 1, 0, 0, 24'h0,      32'h214,      1, 1,  0, 1, 0, 0, 0, "add_after_wait");
        // Wrap: 0xFFFFFFF8 + 8 = 0, return address 0xFFFFFFFC.
        step(1, 1, 1, 1, 24'd0,      32'hFFFFFFF8, 0, 1,  0, 1, 0, 0, 0, "wrap_resolve");
        exp_tgt = 32'h0;
        exp_lr  = 32'hFFFFFFFC;
        // Taken branch presented during FLUSH is ignored.
        step(1, 1, 1, 1, 24'd7,      32'h300,      0, 1,  0, 0, 1, 1, 1, "branch_in_flush1");
        step(1, 1, 1, 1, 24'd7,      32'h300,      0, 1,  0, 0, 1, 0, 0, "branch_in_flush2");
        step(1, 0, 0, 0, 24'h0,      32'h0,        0, 0,  0, 0, 0, 0, 0, "no_second_pcld");
        // Reset asserted in the first FLUSH cycle.
        step(1, 1, 1, 0, 24'd0,      32'h1000,     0, 1,  0, 1, 0, 0, 0, "pre_reset_branch");
        exp_tgt = 32'h0;
        exp_lr  = 32'h0;
        step(0, 0, 0, 0, 24'h0,      32'h0,        0, 0,  0, 0, 0, 0, 0, "reset_in_flush");
        step(1, 0, 0, 0, 24'h0,      32'h0,        0, 0,  0, 0, 0, 0, 0, "after_reset");
        step(1, 1, 0, 0, 24'h0,      32'h4,        1, 1,  1, 0, 0, 0, 0, "idle_after_reset");
        step(1, 0, 0, 0, 24'h0,      32'h0,        0, 0,  0, 0, 0, 0, 0, "final_idle");

        // Let the monitor drain the queue, with a bounded wait.
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Resolves conditional execution and B/BL branches for the instruction in the decode stage. It consumes the `cond_pass` result produced by the condition-tester stage, which evaluates `IR[31:28]` against the flag register. It generates a stall when a flag-setting instruction in execute has not yet loaded the flag register. For taken branches it loads the PC with the branch target, writes the link register for BL, and flushes the younger pipeline slots.

## Interface
Parameters:
- `FLUSH_CYCLES`, 2, cycles `flush` is held after a taken branch (IF and ID slots); legal range 1..7
- `PC_W`, 32, PC/LR width

Ports:
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `id_valid`  in  1  decode slot holds a real instruction
- `id_is_branch`  in  1  instruction is B/BL
- `id_link`  in  1  L bit (BL)
- `id_imm24`  in  24  branch offset field, signed word offset
- `id_pc`  in  PC_W  address of the decode-stage instruction
- `ex_s_pending`  in  1  instruction in execute asserts flag-register load at the coming edge
- `cond_pass`  in  1  condition-tester output for the decode instruction vs current flags
- `exec_en`  out  1  decode instruction is allowed to take effect (combinational)
- `stall`  out  1  hold IF/ID this cycle, insert a bubble into EX (combinational)
- `flush`  out  1  invalidate IF/ID contents (registered)
- `pc_ld`  out  1  one-cycle PC load strobe (registered)
- `pc_target`  out  PC_W  branch target (registered)
- `lr_we`  out  1  one-cycle link-register write strobe (registered)
- `lr_data`  out  PC_W  return address (registered)

## Operation
- States: IDLE, FLAG_WAIT, FLUSH; 3-bit flush counter `fcnt`.
- IDLE, `id_valid=0`:
  - all strobes 0, `exec_en=0`; stay in IDLE.
- IDLE, `id_valid=1` and `ex_s_pending=1`:
  - `stall=1`, `exec_en=0`; go to FLAG_WAIT.
  - `cond_pass` is ignored this cycle because the flags are stale.
- IDLE, `id_valid=1` and `ex_s_pending=0`, or FLAG_WAIT with `id_valid=1`: resolve.
  - `exec_en=cond_pass`.
  - If `id_is_branch & cond_pass`:
    - register `pc_target = id_pc + 8 + (sign_extend(id_imm24) << 2)`, truncated modulo 2^PC_W;
    - `pc_ld <= 1`;
    - if `id_link`: `lr_we <= 1`, `lr_data <= id_pc + 4` (mod 2^PC_W);
    - `fcnt <= FLUSH_CYCLES`; go to FLUSH.
  - Otherwise return to or stay in IDLE.
- FLAG_WAIT:
  - lasts exactly one cycle; `stall=0`.
  - `ex_s_pending` is ignored here, since EX holds the bubble.
  - If `id_valid=0`, return to IDLE.
- FLUSH:
  - `flush=1` and `exec_en=0`; all decode inputs are ignored.
  - `fcnt` decrements each cycle; go to IDLE when `fcnt` reaches 1.
- Not-taken or non-branch instructions never touch `pc_ld`, `lr_we` or `flush`.
- Condition field 1111 gives `cond_pass=0` and is treated as not executed.
- `pc_target` and `lr_data` hold their last value until the next taken branch.

## Timing
- Reset (asynchronous, `reset_n=0`):
  - state IDLE, `fcnt=0`;
  - `flush`, `pc_ld`, `lr_we` = 0; `pc_target`, `lr_data` = 0;
  - `stall`, `exec_en` = 0 while in reset.
- Reset mid-FLUSH or mid-FLAG_WAIT aborts immediately; no residual strobes after release.
- A taken branch resolved in cycle N, meaning it is sampled at edge N+1, gives:
  - `pc_ld` and `lr_we` high during cycle N+1 only;
  - `flush` high for cycles N+1 .. N+FLUSH_CYCLES;
  - `pc_target` and `lr_data` valid from cycle N+1.
- Flag hazard costs exactly 1 stall cycle. The resolve then uses flags updated at the stall edge.
- `stall` and `flush` are never high in the same cycle.
- Back-to-back taken branches are impossible: the second is flushed.

## Test plan
- BEQ, `id_pc=0x100`, `imm24=0xFFFFFE`, `cond_pass=1` -> `pc_ld` 1 cycle, `pc_target=0x100`, `lr_we=0`, `flush` high 2 cycles.
- BL, `id_pc=0x20`, `imm24=3`, `cond_pass=1` -> `pc_target=0x34`, `lr_we=1`, `lr_data=0x24`.
- BNE with `cond_pass=0`, and ADD with `cond_pass=1` -> branch `exec_en=0`, ADD `exec_en=1`; no `pc_ld`, `flush` or `lr_we`.
- `ex_s_pending=1` with a branch in ID -> `stall=1` one cycle, `exec_en=0`. Next cycle `cond_pass=1` -> taken, `pc_ld` follows.
- Wrap: `id_pc=0xFFFFFFF8`, `imm24=0`, taken -> `pc_target=0x00000000`. Then `id_valid=1` with a branch during FLUSH -> ignored, no second `pc_ld`.
- `reset_n` low in the first FLUSH cycle -> `flush`, `pc_ld`, `pc_target` = 0 immediately; IDLE after release.
